// File: rtl/pfpu_dma_rd_if.sv
// rtl/pfpu_dma_rd_if.sv - Wishbone read bus and vertex stream bundle for pfpu_dma_rd
interface pfpu_dma_rd_if #(
    parameter int MESH_BITS = 7
);
    logic [31:0]          wbm_adr_o;
    logic                 wbm_cyc_o;
    logic                 wbm_stb_o;
    logic                 wbm_we_o;
    logic [31:0]          wbm_dat_i;
    logic                 wbm_ack_i;
    logic                 wbm_err_i;

    logic                 vtx_valid;
    logic                 vtx_ready;
    logic [MESH_BITS-1:0] vtx_x;
    logic [MESH_BITS-1:0] vtx_y;
    logic [31:0]          vtx_d1;
    logic [31:0]          vtx_d2;

    // DMA side: drives the bus request and the vertex stream
    modport master (
        output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output vtx_valid, vtx_x, vtx_y, vtx_d1, vtx_d2,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  vtx_ready
    );

    // Memory / consumer side
    modport slave (
        input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  vtx_valid, vtx_x, vtx_y, vtx_d1, vtx_d2,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        output vtx_ready
    );
endinterface

// File: rtl/pfpu_dma_rd.sv
// rtl/pfpu_dma_rd.sv - mesh vertex read DMA; optional bus-error abort under PFPU_DMA_RD_ERR_EN
module pfpu_dma_rd #(
    parameter int MESH_BITS = 7
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [28:0]          dma_base,
    input  logic [MESH_BITS-1:0] hmeshlast,
    input  logic [MESH_BITS-1:0] vmeshlast,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    pfpu_dma_rd_if.master        bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD1     = 2'd1;
    localparam logic [1:0] S_RD2     = 2'd2;
    localparam logic [1:0] S_PRESENT = 2'd3;

    localparam logic [MESH_BITS-1:0] MESH_ONE = {{(MESH_BITS-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [28:0]          base_q, base_d;
    logic [MESH_BITS-1:0] hlast_q, hlast_d;
    logic [MESH_BITS-1:0] vlast_q, vlast_d;
    logic [MESH_BITS-1:0] x_q, x_d;
    logic [MESH_BITS-1:0] y_q, y_d;
    logic [31:0]          d1_q, d1_d;
    logic [31:0]          d2_q, d2_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [28:0]          vstart;
    logic                 last_vtx;
    logic                 bus_err;

    // Vertex pair index; {y,x} packs the mesh position, wrapping modulo 2^29
    assign vstart   = base_q + {{(29 - 2*MESH_BITS){1'b0}}, y_q, x_q};
    assign last_vtx = (x_q == hlast_q) && (y_q == vlast_q);

`ifdef PFPU_DMA_RD_ERR_EN
    assign bus_err = bus.wbm_err_i;
`else
    // Bus errors are not honoured; the cycle simply waits for an ack
    logic unused_wbm_err;
    assign unused_wbm_err = bus.wbm_err_i;
    assign bus_err        = 1'b0;
`endif

    // Next-state logic: frame scan and Wishbone word sequencing
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        hlast_d = hlast_q;
        vlast_d = vlast_q;
        x_d     = x_q;
        y_d     = y_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = dma_base;
                    hlast_d = hmeshlast;
                    vlast_d = vmeshlast;
                    x_d     = '0;
                    y_d     = '0;
                    err_d   = 1'b0;
                    state_d = S_RD1;
                end
            end
            S_RD1: begin
                if (bus_err) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.wbm_ack_i) begin
                    d1_d    = bus.wbm_dat_i;
                    state_d = S_RD2;
                end
            end
            S_RD2: begin
                if (bus_err) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.wbm_ack_i) begin
                    d2_d    = bus.wbm_dat_i;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.vtx_ready) begin
                    if (last_vtx) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD1;
                        if (x_q == hlast_q) begin
                            x_d = '0;
                            y_d = y_q + MESH_ONE;
                        end else begin
                            x_d = x_q + MESH_ONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers, cleared asynchronously so a reset drops any bus cycle at once
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            hlast_q <= '0;
            vlast_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            hlast_q <= hlast_d;
            vlast_q <= vlast_d;
            x_q     <= x_d;
            y_q     <= y_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Word address: bit 2 selects the first or second word of the vertex pair
    always_comb begin
        bus.wbm_adr_o = 32'd0;
        if (state_q == S_RD1) begin
            bus.wbm_adr_o = {vstart, 3'b000};
        end else if (state_q == S_RD2) begin
            bus.wbm_adr_o = {vstart, 3'b100};
        end
    end

    assign bus.wbm_cyc_o = (state_q == S_RD1) || (state_q == S_RD2);
    assign bus.wbm_stb_o = (state_q == S_RD1) || (state_q == S_RD2);
    assign bus.wbm_we_o  = 1'b0;

    assign bus.vtx_valid = (state_q == S_PRESENT);
    assign bus.vtx_x     = x_q;
    assign bus.vtx_y     = y_q;
    assign bus.vtx_d1    = d1_q;
    assign bus.vtx_d2    = d2_q;

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_pfpu_dma_rd.sv
// tb/tb_pfpu_dma_rd.sv - scoreboard bench for pfpu_dma_rd with memory and consumer models
module tb_pfpu_dma_rd;

    localparam int MB = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [28:0]   dma_base;
    logic [MB-1:0] hlast;
    logic [MB-1:0] vlast;
    logic          busy;
    logic          done;
    logic          err;

    pfpu_dma_rd_if #(.MESH_BITS(MB)) bus ();

    pfpu_dma_rd #(.MESH_BITS(MB)) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .start     (start),
        .dma_base  (dma_base),
        .hmeshlast (hlast),
        .vmeshlast (vlast),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MB-1:0] x;
        logic [MB-1:0] y;
        logic [31:0]   d1;
        logic [31:0]   d2;
    } vtx_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    vtx_t        exp_vtx[$];
    logic [31:0] exp_adr[$];
    int          done_seen = 0;
    int          done_exp  = 0;
    int          cyc = 0;
    int          first_stb_cyc = -1;
    int          done_cyc = 0;

    bit          rdy_rand = 0;
    bit          stall_on = 0;
    int          stall_cnt = 0;
    bit          rand_wait = 0;
    int          max_wait = 0;
    bit          inj_pending = 0;
    logic [31:0] inj_adr = 32'd0;

    bit          req_active = 0;
    logic [31:0] req_adr;
    int          wait_cnt = 0;
    bit          hold_act = 0;
    vtx_t        hold_v;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Memory contents: two fixed words for the directed frame, a hash everywhere else
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_8000) return 32'hAAAA_0001;
        if (a == 32'h0000_8004) return 32'hAAAA_0002;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Reference: raster scan, pair index base + y*2^MB + x, word addresses 8*idx and 8*idx+4
    task automatic plan_frame(input logic [28:0] b, input int h, input int v, input int abort_idx);
        int   idx;
        logic [28:0] vs;
        vtx_t e;
        idx = 0;
        for (int yy = 0; yy <= v; yy++) begin
            for (int xx = 0; xx <= h; xx++) begin
                if (abort_idx < 0 || idx <= abort_idx) begin
                    vs = b + 29'(yy * (1 << MB) + xx);
                    exp_adr.push_back({vs, 3'b000});
                    exp_adr.push_back({vs, 3'b100});
                    if (idx != abort_idx) begin
                        e.x  = MB'(xx);
                        e.y  = MB'(yy);
                        e.d1 = mem_word({vs, 3'b000});
                        e.d2 = mem_word({vs, 3'b100});
                        exp_vtx.push_back(e);
                    end
                end
                idx++;
            end
        end
        done_exp++;
    endtask

    // Memory slave, consumer and monitors, all evaluated on the falling edge
    initial begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_dat_i = 32'd0;
        bus.vtx_ready = 1'b0;
        forever begin
            vtx_t cur;
            @(negedge clk);
            cyc++;
            if (rst) begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
                bus.vtx_ready = 1'b0;
                req_active    = 0;
                hold_act      = 0;
            end else begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
                bus.wbm_dat_i = $urandom;
                if (bus.wbm_stb_o) begin
                    if (first_stb_cyc < 0) first_stb_cyc = cyc;
                    if (!req_active) begin
                        req_active = 1;
                        req_adr    = bus.wbm_adr_o;
                        wait_cnt   = rand_wait ? $urandom_range(0, max_wait) : max_wait;
                        check("adr_expected", exp_adr.size() > 0, 1);
                        if (exp_adr.size() > 0) check("adr", bus.wbm_adr_o, exp_adr.pop_front());
                    end else begin
                        check("adr_hold", bus.wbm_adr_o, req_adr);
                    end
                    if (wait_cnt == 0) begin
                        if (inj_pending && bus.wbm_adr_o == inj_adr) begin
                            bus.wbm_err_i = 1'b1;
                            inj_pending   = 0;
                        end else begin
                            bus.wbm_ack_i = 1'b1;
                            bus.wbm_dat_i = mem_word(bus.wbm_adr_o);
                            req_active    = 0;
                        end
                    end else begin
                        wait_cnt--;
                    end
                end else begin
                    req_active = 0;
                end

                if (stall_on && bus.vtx_valid && bus.vtx_x == 1 && bus.vtx_y == 0 && stall_cnt < 5) begin
                    bus.vtx_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.vtx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                end

                if (bus.vtx_valid) begin
                    cur.x  = bus.vtx_x;
                    cur.y  = bus.vtx_y;
                    cur.d1 = bus.vtx_d1;
                    cur.d2 = bus.vtx_d2;
                    check("no_stb_in_present", bus.wbm_stb_o, 0);
                    if (hold_act) check("stall_stable", cur, hold_v);
                    if (bus.vtx_ready) begin
                        hold_act = 0;
                        check("vtx_expected", exp_vtx.size() > 0, 1);
                        if (exp_vtx.size() > 0) check("vtx", cur, exp_vtx.pop_front());
                    end else begin
                        hold_act = 1;
                        hold_v   = cur;
                    end
                end else begin
                    hold_act = 0;
                end

                if (done) begin
                    done_seen++;
                    done_cyc = cyc;
                    check("busy_low_at_done", busy, 0);
                end
            end
        end
    end

    task automatic kick(input logic [28:0] b, input int h, input int v, input int abort_idx);
        dma_base      = b;
        hlast         = MB'(h);
        vlast         = MB'(v);
        first_stb_cyc = -1;
        plan_frame(b, h, v, abort_idx);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check("stb_after_start", bus.wbm_stb_o, 1);
        check("busy_after_start", busy, 1);
        check("err_clear_after_start", err, 0);
    endtask

    task automatic finish_frame(input int budget, input logic exp_err);
        int n;
        n = 0;
        while (done_seen < done_exp && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_timeout", done_seen >= done_exp, 1);
        repeat (3) begin @(negedge clk); #1; end
        check("done_count", done_seen, done_exp);
        check("vtx_leftover", exp_vtx.size(), 0);
        check("adr_leftover", exp_adr.size(), 0);
        check("err_after_frame", err, exp_err);
        check("idle_after_frame", busy, 0);
        done_exp = done_seen;
        exp_vtx.delete();
        exp_adr.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [28:0] vs;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dma_base = 29'd0;
        hlast    = '0;
        vlast    = '0;
        repeat (3) begin @(negedge clk); #1; end
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", bus.vtx_valid, 0);
        check("rst_stb", bus.wbm_stb_o, 0);
        check("rst_cyc", bus.wbm_cyc_o, 0);
        check("rst_we", bus.wbm_we_o, 0);
        check("rst_adr", bus.wbm_adr_o, 0);
        check("rst_xy", {bus.vtx_x, bus.vtx_y}, 0);
        check("rst_data", {bus.vtx_d1, bus.vtx_d2}, 0);
        rst = 1'b0;
        repeat (2) begin @(negedge clk); #1; end

        // Single vertex frame, zero-wait memory: 3 cycles from first stb
        kick(29'h000_1000, 0, 0, -1);
        finish_frame(50, 1'b0);
        check("lat_single", done_cyc - first_stb_cyc, 3);

        // 3x2 mesh, back-to-back: 3 cycles per vertex
        kick(29'd0, 2, 1, -1);
        finish_frame(200, 1'b0);
        check("lat_mesh", done_cyc - first_stb_cyc, 18);

        // Delayed acks and a 5-cycle consumer stall at vertex (1,0)
        max_wait  = 3;
        stall_on  = 1;
        stall_cnt = 0;
        kick(29'h000_0040, 2, 1, -1);
        finish_frame(400, 1'b0);
        check("stall_cycles", stall_cnt, 5);
        stall_on = 0;
        max_wait = 0;

        // Base wraps at x=1; start while busy is ignored
        kick(29'h1FFF_FFFF, 1, 0, -1);
        repeat (2) begin @(negedge clk); #1; end
        dma_base = 29'h00A_BCDE;
        hlast    = MB'(5);
        start    = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        finish_frame(100, 1'b0);

        // Reset during the second word read
        kick(29'h012_3450, 3, 3, -1);
        n = 0;
        while (!(bus.wbm_stb_o && bus.wbm_adr_o[2]) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("reach_rd2", bus.wbm_stb_o && bus.wbm_adr_o[2], 1);
        rst = 1'b1;
        #1;
        check("rst_mid_stb", bus.wbm_stb_o, 0);
        check("rst_mid_cyc", bus.wbm_cyc_o, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_adr", bus.wbm_adr_o, 0);
        exp_vtx.delete();
        exp_adr.delete();
        done_exp = done_seen;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(negedge clk); #1; end

        // Bus error on the second word of vertex (1,0)
        vs          = 29'h000_0201;
        inj_adr     = {vs, 3'b100};
        inj_pending = 1;
`ifdef PFPU_DMA_RD_ERR_EN
        kick(29'h000_0200, 1, 0, 1);
        finish_frame(100, 1'b1);
`else
        kick(29'h000_0200, 1, 0, -1);
        finish_frame(100, 1'b0);
`endif
        check("err_injected", inj_pending, 0);
        inj_pending = 0;
        kick(29'h000_0300, 0, 0, -1);
        finish_frame(50, 1'b0);

        // Randomized frames with random waits and consumer backpressure
        rdy_rand  = 1;
        rand_wait = 1;
        max_wait  = 2;
        for (int f = 0; f < 8; f++) begin
            logic [28:0] b;
            b = (f % 3 == 0) ? 29'h1FFF_FFF0 + 29'($urandom_range(0, 15)) : 29'($urandom);
            kick(b, $urandom_range(0, 3), $urandom_range(0, 3), -1);
            finish_frame(3000, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
